// File: rtl/serial_link_pkg.sv
// Shared definitions for the bit-serial link: FSM state encoding, line levels
// and the parity helper used by both the transmit framer and the receiver.
package serial_link_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } link_state_e;

   localparam logic LINE_IDLE = 1'b1;
   localparam logic START_BIT = 1'b0;
   localparam logic STOP_BIT  = 1'b1;

   localparam int MAX_DATA_W = 16;

   // Even parity over a word zero-extended to the widest supported frame.
   function automatic logic even_parity(input logic [MAX_DATA_W-1:0] word);
      return ^word;
   endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while enabled, pulses tick_o
// in the last cycle of each bit and restarts; clr_i holds it at zero.
module baud_tick_gen #(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clr_i,
   input  logic en_i,
   output logic tick_o
);

   localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

   logic [CNT_W-1:0] cnt_q;

   assign tick_o = en_i && (cnt_q == CNT_W'(CLKS_PER_BIT - 1));

   always_ff @(posedge clk_i) begin
      if (rst_i || clr_i) begin
         cnt_q <= '0;
      end else if (en_i) begin
         if (tick_o) begin
            cnt_q <= '0;
         end else begin
            cnt_q <= cnt_q + CNT_W'(1);
         end
      end else begin
         cnt_q <= cnt_q;
      end
   end

endmodule

// File: rtl/serial_tx_framer.sv
// Bit-serial transmit framer: start 0, DATA_W bits LSB first, stop 1.
// Define SERIAL_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module serial_tx_framer
   import serial_link_pkg::*;
#(
   parameter int DATA_W       = 8,
   parameter int CLKS_PER_BIT = 16
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic [DATA_W-1:0] D,
   input  logic              VALID,
   output logic              READY,
   output logic              TXD,
   output logic              BUSY
);

   localparam int BIT_W = $clog2(DATA_W + 1);

   link_state_e       state_q;
   logic [DATA_W-1:0] shreg_q;
   logic [DATA_W-1:0] shreg_d;
   logic [BIT_W-1:0]  bit_q;
   logic              txd_q;
   logic              ready_q;
   logic              busy_q;
   logic              bit_tick;
   logic              last_bit;
`ifdef SERIAL_TX_PARITY_EN
   logic              parity_q;
`endif

   baud_tick_gen #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_baud (
      .clk_i  (CLK),
      .rst_i  (RST),
      .clr_i  (state_q == ST_IDLE),
      .en_i   (state_q != ST_IDLE),
      .tick_o (bit_tick)
   );

   assign shreg_d  = shreg_q >> 1;
   assign last_bit = (bit_q == BIT_W'(DATA_W - 1));

   // TXD is registered, so each state loads the level of the bit it enters.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q  <= ST_IDLE;
         txd_q    <= LINE_IDLE;
         ready_q  <= 1'b1;
         busy_q   <= 1'b0;
         shreg_q  <= '0;
         bit_q    <= '0;
`ifdef SERIAL_TX_PARITY_EN
         parity_q <= 1'b0;
`endif
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (VALID && ready_q) begin
                  state_q  <= ST_START;
                  txd_q    <= START_BIT;
                  ready_q  <= 1'b0;
                  busy_q   <= 1'b1;
                  shreg_q  <= D;
`ifdef SERIAL_TX_PARITY_EN
                  parity_q <= even_parity(MAX_DATA_W'(D));
`endif
               end
            end
            ST_START: begin
               if (bit_tick) begin
                  state_q <= ST_DATA;
                  txd_q   <= shreg_q[0];
               end
            end
            ST_DATA: begin
               if (bit_tick) begin
                  shreg_q <= shreg_d;
                  if (last_bit) begin
                     bit_q   <= '0;
`ifdef SERIAL_TX_PARITY_EN
                     state_q <= ST_PARITY;
                     txd_q   <= parity_q;
`else
                     state_q <= ST_STOP;
                     txd_q   <= STOP_BIT;
`endif
                  end else begin
                     bit_q <= bit_q + BIT_W'(1);
                     txd_q <= shreg_d[0];
                  end
               end
            end
`ifdef SERIAL_TX_PARITY_EN
            ST_PARITY: begin
               if (bit_tick) begin
                  state_q <= ST_STOP;
                  txd_q   <= STOP_BIT;
               end
            end
`endif
            ST_STOP: begin
               if (bit_tick) begin
                  state_q <= ST_IDLE;
                  txd_q   <= LINE_IDLE;
                  ready_q <= 1'b1;
                  busy_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= ST_IDLE;
               txd_q   <= LINE_IDLE;
               ready_q <= 1'b1;
               busy_q  <= 1'b0;
               bit_q   <= '0;
            end
         endcase
      end
   end

   assign READY = ready_q;
   assign TXD   = txd_q;
   assign BUSY  = busy_q;

endmodule

// File: tb/tb_serial_tx_framer.sv
// Directed + randomized bench for serial_tx_framer (DATA_W=8, CLKS_PER_BIT=4);
// expected line levels come from a frame model built as a list of bits.
module tb_serial_tx_framer;

   localparam int DW  = 8;
   localparam int CPB = 4;
`ifdef SERIAL_TX_PARITY_EN
   localparam int NB  = DW + 3;
`else
   localparam int NB  = DW + 2;
`endif
   localparam int FRAME_CYC = NB * CPB;

   logic          CLK = 1'b0;
   logic          RST;
   logic [DW-1:0] D;
   logic          VALID;
   logic          READY;
   logic          TXD;
   logic          BUSY;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int last_accept = -1;

   serial_tx_framer #(
      .DATA_W       (DW),
      .CLKS_PER_BIT (CPB)
   ) dut (
      .CLK   (CLK),
      .RST   (RST),
      .D     (D),
      .VALID (VALID),
      .READY (READY),
      .TXD   (TXD),
      .BUSY  (BUSY)
   );

   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input int obs, input int exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Reference frame: list of line levels, one entry per bit period.
   function automatic void build_frame(input logic [DW-1:0] w, output logic bits [NB]);
      int n = 0;
      bits[n++] = 1'b0;
      for (int i = 0; i < DW; i++) bits[n++] = w[i];
`ifdef SERIAL_TX_PARITY_EN
      bits[n++] = ^w;
`endif
      bits[n] = 1'b1;
   endfunction

   task automatic check_idle(input string tag);
      check({tag, "_txd"},   TXD,   1);
      check({tag, "_ready"}, READY, 1);
      check({tag, "_busy"},  BUSY,  0);
   endtask

   // Starts at a negedge with the DUT idle; ends at the negedge of the gap cycle.
   task automatic run_frame(input logic [DW-1:0] w, input bit hold_valid,
                            input bit garble, input bit check_gap);
      logic bits [NB];
      int   n = 0;
      while (!READY && n < 200) begin
         @(negedge CLK);
         n++;
      end
      check("ready_wait", READY, 1);
      build_frame(w, bits);
      D     = w;
      VALID = 1'b1;
      @(posedge CLK);
      for (int k = 0; k < FRAME_CYC; k++) begin
         @(negedge CLK);
         if (k == 0) begin
            if (check_gap) check("accept_interval", cyc - last_accept, FRAME_CYC + 1);
            last_accept = cyc;
         end
         check($sformatf("txd_w%02h_k%0d", w, k), TXD, bits[k / CPB]);
         check("busy_frame",  BUSY,  1);
         check("ready_frame", READY, 0);
         if (garble && k < FRAME_CYC - 1) begin
            VALID = 1'($urandom);
            D     = DW'($urandom);
         end else begin
            VALID = hold_valid;
         end
      end
      @(negedge CLK);
      check_idle("gap");
   endtask

   initial begin
      logic [DW-1:0] w;
      RST   = 1'b1;
      VALID = 1'b1;
      D     = DW'($urandom);

      // Reset held with VALID high: line stays idle.
      repeat (3) begin
         @(negedge CLK);
         check_idle("reset");
      end
      RST   = 1'b0;
      VALID = 1'b0;
      @(negedge CLK);
      check_idle("post_reset");

      // Single word, one-cycle pulse.
      run_frame(8'hA5, 1'b0, 1'b0, 1'b0);
      @(negedge CLK);
      check_idle("after_a5");

      // Back-to-back with VALID held high.
      run_frame(8'h00, 1'b1, 1'b0, 1'b0);
      run_frame(8'hFF, 1'b1, 1'b0, 1'b1);
      VALID = 1'b0;
      @(negedge CLK);

      // Mid-frame VALID pulses and D changes are ignored.
      D     = 8'h81;
      VALID = 1'b1;
      @(posedge CLK);
      begin
         logic bits [NB];
         build_frame(8'h81, bits);
         for (int k = 0; k < FRAME_CYC; k++) begin
            @(negedge CLK);
            check($sformatf("txd_81_k%0d", k), TXD, bits[k / CPB]);
            if (k < FRAME_CYC - 1) begin
               VALID = ~VALID;
               D     = 8'h3C;
            end else begin
               VALID = 1'b0;
            end
         end
      end
      @(negedge CLK);
      check_idle("after_81");

      // Reset while transmitting data bit 3.
      w     = DW'($urandom);
      D     = w;
      VALID = 1'b1;
      @(posedge CLK);
      @(negedge CLK);
      VALID = 1'b0;
      repeat (4 * CPB) @(negedge CLK);
      check("txd_bit3", TXD, w[3]);
      RST = 1'b1;
      @(negedge CLK);
      check_idle("abort");
      RST = 1'b0;
      run_frame(8'h55, 1'b0, 1'b0, 1'b0);

`ifdef SERIAL_TX_PARITY_EN
      run_frame(8'h07, 1'b0, 1'b0, 1'b0);
      run_frame(8'h03, 1'b0, 1'b0, 1'b0);
`endif

      // Randomized words, idle gaps and mid-frame noise.
      for (int i = 0; i < 8; i++) begin
         int gap = $urandom_range(0, 3);
         for (int g = 0; g < gap; g++) begin
            @(negedge CLK);
            check_idle("rand_gap");
         end
         run_frame(DW'($urandom), 1'b0, 1'($urandom), 1'b0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/serial_tx_framer.md
Name: serial_tx_framer

Overview:
- Transmit end of the lab's bit-serial link: accepts a parallel word over a valid/ready handshake and shifts it out on a single line.
- Frame format: start bit 0, DATA_W data bits LSB first, optional parity bit, stop bit 1.
- Built from registered state only; every output is a flip-flop output or decoded from state. Sits between a parallel data source (counter, register file, test pattern) and the serial receiver on the far end.

Parameters:
DATA_W, 8, data bits per frame (1..16)
CLKS_PER_BIT, 16, CLK cycles each bit is held on TXD (>=2)

Ports:
CLK  input  1  system clock, all state updates on rising edge
RST  input  1  reset, synchronous and active-high
D  input  DATA_W  parallel word, sampled only on acceptance
VALID  input  1  source has a word on D
READY  output  1  block can accept a word; high only in IDLE
TXD  output  1  serial line, registered, idles high
BUSY  output  1  frame in progress (state != IDLE)

Behaviour:
- Reset: RST high at a rising edge forces state=IDLE, TXD=1, BUSY=0, READY=1, shift register=0, bit and baud counters=0. RST has priority over all other inputs, including mid-frame: the frame is aborted and TXD is 1 after that edge.
- States:
  - IDLE -> START on VALID&&READY.
  - START -> DATA after CLKS_PER_BIT cycles.
  - DATA -> (PARITY if enabled, else STOP) after DATA_W bits.
  - PARITY -> STOP.
  - STOP -> IDLE after CLKS_PER_BIT cycles.
- Handshake:
  - A transfer occurs on any rising edge where VALID=1 and READY=1.
  - D is captured into the shift register on that edge; READY=0 and BUSY=1 from the next cycle.
  - VALID and D are ignored while not in IDLE, and VALID has no effect until READY.
- Latency: TXD=0 in the first cycle after acceptance.
- Bit timing:
  - Baud counter counts 0..CLKS_PER_BIT-1 and is cleared on entry to every bit, so each bit is held exactly CLKS_PER_BIT cycles.
  - In DATA, TXD = shreg[0]; the register shifts right on the last cycle of each bit.
  - Bit counter runs 0..DATA_W-1 and wraps to 0 on DATA exit.
- Frame length: N = 2+DATA_W (+1 with parity) bits; non-IDLE for exactly N*CLKS_PER_BIT cycles.
- Back-to-back: at least one IDLE cycle between frames. With VALID held high, acceptance edges are N*CLKS_PER_BIT+1 cycles apart, and TXD=1 during that IDLE cycle.
- Widths: baud counter width is clog2(CLKS_PER_BIT); bit counter width is clog2(DATA_W+1). No arithmetic overflow; counters compare against the terminal count minus one.

Optional Feature:
- Macro SERIAL_TX_PARITY_EN.
- Defined:
  - PARITY state inserted after DATA; TXD = even parity (XOR of the accepted D) for CLKS_PER_BIT cycles.
  - Parity is computed at acceptance and held in a register, so later changes on D cannot corrupt it.
- Undefined: no PARITY state or parity register; DATA goes directly to STOP, and N = 2+DATA_W.

Decomposition:
- Shared package serial_link_pkg:
  - State encoding constants: IDLE=0, START=1, DATA=2, PARITY=3, STOP=4 (3-bit).
  - Line levels LINE_IDLE=1, START_BIT=0, STOP_BIT=1.
  - These are shared with the matching receiver.
- Sub-module baud_tick_gen (counter with clear input and terminal-count pulse, parameter CLKS_PER_BIT). It is reused by the receiver; the framer FSM instantiates one.

Test Plan:
- Reset: hold RST 3 cycles with VALID=1 -> TXD=1, READY=1, BUSY=0 throughout; no frame starts until RST=0.
- Single word, DATA_W=8, CLKS_PER_BIT=4, D=0xA5 pulsed one cycle:
  - TXD per 4-cycle bit = 0,1,0,1,0,0,1,0,1,1.
  - BUSY high for exactly 40 cycles; READY back high at cycle 41.
- Back-to-back 0x00 then 0xFF, VALID held:
  - Second acceptance exactly 41 cycles after the first.
  - TXD=1 in the single gap cycle; second frame data bits all 1.
- VALID pulses and D changes to 0x3C mid-frame of 0x81 -> ignored; transmitted bits match 0x81 only.
- RST asserted in DATA bit 3 -> TXD=1, READY=1, BUSY=0 the next cycle. A new word 0x55 is then sent with a full, correct frame.
- SERIAL_TX_PARITY_EN defined, D=0x07 -> parity bit 1, BUSY 44 cycles. D=0x03 -> parity bit 0.
